// File: rtl/fundamental_frame_scheduler.sv
// rtl/fundamental_frame_scheduler.sv - round-robin frame scheduler sharing one fundamental bin finder between two channels
module fundamental_frame_scheduler #(
    parameter int FRAME_LEN = 1024,
    parameter int MAG_W     = 48,
    parameter int BIN_W     = 5,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               reset,
    // channel 0 magnitude stream
    input  logic [MAG_W-1:0]   i_mag0_tdata,
    input  logic               i_mag0_tvalid,
    output logic               o_mag0_tready,
    // channel 1 magnitude stream
    input  logic [MAG_W-1:0]   i_mag1_tdata,
    input  logic               i_mag1_tvalid,
    output logic               o_mag1_tready,
    // shared finder magnitude input
    output logic [MAG_W-1:0]   o_finder_mag_tdata,
    output logic               o_finder_mag_tvalid,
    output logic               o_finder_mag_tlast,
    input  logic               i_finder_mag_tready,
    // finder bin result
    input  logic [BIN_W-1:0]   i_finder_bin_tdata,
    input  logic               i_finder_bin_tvalid,
    output logic               o_finder_bin_tready,
    // tagged result {timeout, chan, bin}
    output logic [BIN_W+1:0]   o_result_tdata,
    output logic               o_result_tvalid,
    input  logic               i_result_tready,
    // per-channel history
    output logic [BIN_W-1:0]   o_last_bin0,
    output logic [BIN_W-1:0]   o_last_bin1,
    output logic [1:0]         o_last_valid,
    output logic [15:0]        o_timeout_count
);

    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_REPORT
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_sel;
    logic               r_last_served;
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [BIN_W-1:0]   r_bin;
    logic               r_timeout;
    logic [BIN_W-1:0]   r_last_bin0;
    logic [BIN_W-1:0]   r_last_bin1;
    logic [1:0]         r_last_valid;
    logic [15:0]        r_timeout_count;

    logic               w_grant_sel;
    logic               w_sel_tvalid;
    logic [MAG_W-1:0]   w_sel_tdata;
    logic               w_last_beat;
    logic               w_mag_hs;
    logic               w_wait_expired;
    logic               w_result_hs;

    assign w_sel_tvalid   = r_sel ? i_mag1_tvalid : i_mag0_tvalid;
    assign w_sel_tdata    = r_sel ? i_mag1_tdata  : i_mag0_tdata;
    assign w_last_beat    = (r_beat_cnt == LAST_BEAT);
    assign w_mag_hs       = (r_state == S_STREAM) && w_sel_tvalid && i_finder_mag_tready;
    assign w_wait_expired = (r_wait_cnt == LAST_WAIT);
    assign w_result_hs    = (r_state == S_REPORT) && i_result_tready;

    // Late or stale finder results are simply swallowed outside WAIT.
    assign o_finder_bin_tready = 1'b1;
    assign o_result_tdata      = {r_timeout, r_sel, r_bin};
    assign o_last_bin0         = r_last_bin0;
    assign o_last_bin1         = r_last_bin1;
    assign o_last_valid        = r_last_valid;
    assign o_timeout_count     = r_timeout_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state        = r_state;
        w_grant_sel         = r_sel;
        o_mag0_tready       = 1'b0;
        o_mag1_tready       = 1'b0;
        o_finder_mag_tvalid = 1'b0;
        o_finder_mag_tdata  = '0;
        o_finder_mag_tlast  = 1'b0;
        o_result_tvalid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie the channel not served last time wins.
                if (i_mag0_tvalid && i_mag1_tvalid) begin
                    w_grant_sel  = ~r_last_served;
                    w_next_state = S_STREAM;
                end else if (i_mag0_tvalid) begin
                    w_grant_sel  = 1'b0;
                    w_next_state = S_STREAM;
                end else if (i_mag1_tvalid) begin
                    w_grant_sel  = 1'b1;
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                o_finder_mag_tvalid = w_sel_tvalid;
                o_finder_mag_tdata  = w_sel_tdata;
                o_finder_mag_tlast  = w_last_beat;
                o_mag0_tready       = ~r_sel & i_finder_mag_tready;
                o_mag1_tready       = r_sel & i_finder_mag_tready;
                if (w_mag_hs && w_last_beat) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_finder_bin_tvalid || w_wait_expired) begin
                    w_next_state = S_REPORT;
                end
            end
            S_REPORT: begin
                o_result_tvalid = 1'b1;
                if (i_result_tready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel           <= 1'b0;
            r_last_served   <= 1'b1;
            r_beat_cnt      <= '0;
            r_wait_cnt      <= '0;
            r_bin           <= '0;
            r_timeout       <= 1'b0;
            r_last_bin0     <= '0;
            r_last_bin1     <= '0;
            r_last_valid    <= 2'b00;
            r_timeout_count <= 16'd0;
        end else begin
            if (r_state == S_IDLE) begin
                r_sel <= w_grant_sel;
            end

            if (w_mag_hs) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end

            if (r_state == S_WAIT) begin
                if (i_finder_bin_tvalid) begin
                    r_wait_cnt <= '0;
                    r_bin      <= i_finder_bin_tdata;
                    r_timeout  <= 1'b0;
                end else if (w_wait_expired) begin
                    r_wait_cnt <= '0;
                    r_bin      <= '0;
                    r_timeout  <= 1'b1;
                    if (r_timeout_count != 16'hFFFF) begin
                        r_timeout_count <= r_timeout_count + 16'd1;
                    end
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end

            // A timed-out frame must not overwrite the last good bin.
            if (w_result_hs) begin
                r_last_served <= r_sel;
                if (!r_timeout) begin
                    if (r_sel) begin
                        r_last_bin1     <= r_bin;
                        r_last_valid[1] <= 1'b1;
                    end else begin
                        r_last_bin0     <= r_bin;
                        r_last_valid[0] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fundamental_frame_scheduler.sv
// tb/tb_fundamental_frame_scheduler.sv - directed self-checking bench for fundamental_frame_scheduler
module tb_fundamental_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] mag0_tdata, mag1_tdata, f_tdata;
    logic        mag0_tvalid, mag0_tready, mag1_tvalid, mag1_tready;
    logic        f_tvalid, f_tready, f_tlast;
    logic [4:0]  bin_d = 5'd0;
    logic        bin_v = 1'b0;
    logic        bin_r;
    logic [6:0]  res_tdata;
    logic        res_tvalid;
    logic        res_ready = 1'b1;
    logic [4:0]  last_bin0, last_bin1;
    logic [1:0]  last_valid;
    logic [15:0] tc;

    logic [1:0]  src_en = 2'b00;
    logic        gap0 = 1'b1;
    logic        fr_ok = 1'b1;
    logic        rnd_en = 1'b0;
    logic        exp_ch = 1'b0;
    bit          hs0, hs1;
    int          idx0 = 0, idx1 = 0, fidx = 0, hs_total = 0, frames_done = 0, res_cnt = 0;
    int          checks = 0, failures = 0;
    int          fd, n;

    assign mag0_tdata  = {32'hA0A0_0000, 6'd0, idx0[9:0]};
    assign mag1_tdata  = {32'hB1B1_0000, 6'd0, idx1[9:0]};
    assign mag0_tvalid = src_en[0] & gap0;
    assign mag1_tvalid = src_en[1];
    assign f_tready    = fr_ok;

    always #5 clk = ~clk;

    fundamental_frame_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .i_mag0_tdata        (mag0_tdata),
        .i_mag0_tvalid       (mag0_tvalid),
        .o_mag0_tready       (mag0_tready),
        .i_mag1_tdata        (mag1_tdata),
        .i_mag1_tvalid       (mag1_tvalid),
        .o_mag1_tready       (mag1_tready),
        .o_finder_mag_tdata  (f_tdata),
        .o_finder_mag_tvalid (f_tvalid),
        .o_finder_mag_tlast  (f_tlast),
        .i_finder_mag_tready (f_tready),
        .i_finder_bin_tdata  (bin_d),
        .i_finder_bin_tvalid (bin_v),
        .o_finder_bin_tready (bin_r),
        .o_result_tdata      (res_tdata),
        .o_result_tvalid     (res_tvalid),
        .i_result_tready     (res_ready),
        .o_last_bin0         (last_bin0),
        .o_last_bin1         (last_bin1),
        .o_last_valid        (last_valid),
        .o_timeout_count     (tc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int k = 0;
        while (frames_done < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, 64'(frames_done >= target), 64'd1);
    endtask

    // Finder-side monitor: each beat must be the next beat of the expected channel's frame.
    always @(negedge clk) begin
        hs0 = mag0_tvalid && mag0_tready;
        hs1 = mag1_tvalid && mag1_tready;
        if (res_tvalid && res_ready) res_cnt++;
        if (f_tvalid && f_tready) begin
            check("beat_data", f_tdata, {(exp_ch ? 32'hB1B1_0000 : 32'hA0A0_0000), 16'(fidx)});
            check("beat_tlast", f_tlast, 64'(fidx == 1023));
            check("other_ready", exp_ch ? mag0_tready : mag1_tready, 64'd0);
            fidx++;
            hs_total++;
            if (fidx == 1024) begin
                fidx = 0;
                frames_done++;
            end
        end
    end

    always @(posedge clk) begin
        if (hs0) idx0 = idx0 + 1;
        if (hs1) idx1 = idx1 + 1;
        if (reset) begin
            idx0 = 0;
            idx1 = 0;
            fidx = 0;
            hs_total = 0;
        end
        hs0 = 1'b0;
        hs1 = 1'b0;
        #1;
        if (rnd_en) begin
            gap0  = ($urandom_range(0, 3) != 0);
            fr_ok = ($urandom_range(0, 3) != 0);
        end else begin
            gap0  = 1'b1;
            fr_ok = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", res_tvalid, 0);
        check("rst_res_data", res_tdata, 0);
        check("rst_readies", {mag0_tready, mag1_tready}, 0);
        check("rst_f_valid", f_tvalid, 0);
        check("rst_f_data", f_tdata, 0);
        check("rst_last_valid", last_valid, 0);
        check("rst_timeouts", tc, 0);
        check("rst_last_bins", {last_bin0, last_bin1}, 0);
        check("bin_ready_tied", bin_r, 1);

        // only channel 0 streams, finder answers 7
        @(posedge clk); #1;
        reset = 1'b0;
        src_en = 2'b01;
        @(negedge clk);
        check("t1_grant_cycle_no_data", mag0_tready, 0);
        @(negedge clk);
        check("t1_first_stream_ready", mag0_tready, 1);
        wait_frames(1, 1100, "t1_frame_done");
        src_en = 2'b00;
        tick();
        tick();
        bin_v = 1'b1; bin_d = 5'd7;
        tick();
        bin_v = 1'b0;
        @(negedge clk);
        check("t1_result_latency", res_tvalid, 1);
        check("t1_result_data", res_tdata, 7'h07);
        tick();
        @(negedge clk);
        check("t1_result_once", res_cnt, 1);
        check("t1_last_bin0", last_bin0, 7);
        check("t1_last_valid", last_valid, 2'b01);

        // both channels valid from reset: ch0 then ch1
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        src_en = 2'b11;
        exp_ch = 1'b0;
        fd = frames_done;
        wait_frames(fd + 1, 1100, "t2_ch0_frame_done");
        exp_ch = 1'b1;
        @(negedge clk);
        check("t2_wait_backpressure", {f_tvalid, mag0_tready, mag1_tready}, 0);
        tick();
        bin_v = 1'b1; bin_d = 5'd12;
        tick();
        bin_v = 1'b0;
        @(negedge clk);
        check("t2_result_ch0", {res_tvalid, res_tdata}, {1'b1, 7'd12});
        @(negedge clk);
        check("t2_bubble", {res_tvalid, mag0_tready, mag1_tready}, 0);
        @(negedge clk);
        check("t2_grant_ch1", {mag0_tready, mag1_tready}, 2'b01);
        tick();
        bin_v = 1'b1; bin_d = 5'd30;
        tick();
        bin_v = 1'b0;
        wait_frames(fd + 2, 1100, "t2_ch1_frame_done");
        src_en = 2'b00;
        tick();
        bin_v = 1'b1; bin_d = 5'd3;
        tick();
        bin_v = 1'b0;
        @(negedge clk);
        check("t2_result_ch1", {res_tvalid, res_tdata}, {1'b1, 7'h23});
        tick();
        @(negedge clk);
        check("t2_last_bins", {last_bin0, last_bin1}, {5'd12, 5'd3});
        check("t2_last_valid", last_valid, 2'b11);
        check("t2_result_count", res_cnt, 3);

        // finder silent: timeout after exactly TIMEOUT wait cycles, result held low
        src_en = 2'b01;
        exp_ch = 1'b0;
        wait_frames(fd + 3, 1100, "t3_frame_done");
        src_en = 2'b11;
        res_ready = 1'b0;
        exp_ch = 1'b1;
        repeat (4095) @(posedge clk);
        @(negedge clk);
        check("t3_timeout_not_early", res_tvalid, 0);
        @(negedge clk);
        check("t3_timeout_on_time", {res_tvalid, res_tdata}, {1'b1, 7'h40});
        check("t3_timeout_count", tc, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_hold_stable", {res_tvalid, res_tdata, mag0_tready, mag1_tready},
                  {1'b1, 7'h40, 2'b00});
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("t3_bubble", {res_tvalid, mag0_tready, mag1_tready}, 0);
        check("t3_last_bin_kept", {last_bin0, last_bin1, last_valid}, {5'd12, 5'd3, 2'b11});
        @(negedge clk);
        check("t3_next_grant_ch1", {mag0_tready, mag1_tready}, 2'b01);

        // reset at beat 500 of the ch1 frame
        n = 0;
        while (fidx < 500 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("t6_reach_beat500", fidx, 500);
        #1;
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("t6_rst_outputs", {res_tvalid, f_tvalid, mag0_tready, mag1_tready, last_valid}, 0);
        check("t6_rst_history", {last_bin0, last_bin1, tc}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ch = 1'b0;
        @(negedge clk);
        check("t6_idle_after_rst", {mag0_tready, mag1_tready}, 0);
        @(negedge clk);
        check("t6_ch0_first", {mag0_tready, mag1_tready}, 2'b10);

        // random source gaps and finder backpressure on a ch0 frame
        rnd_en = 1'b1;
        fd = frames_done;
        wait_frames(fd + 1, 5000, "t5_frame_done");
        src_en = 2'b00;
        rnd_en = 1'b0;
        check("t5_handshakes", hs_total, 1024);
        tick();
        bin_v = 1'b1; bin_d = 5'd21;
        tick();
        bin_v = 1'b0;
        @(negedge clk);
        check("t5_result", {res_tvalid, res_tdata}, {1'b1, 7'd21});
        tick();
        @(negedge clk);
        check("t5_last", {last_bin0, last_bin1, last_valid}, {5'd21, 5'd0, 2'b01});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
